// File: rtl/rx_frame_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_assembler_if
//  Description : Byte-stream input and validated-frame output bundle of the
//                receive frame assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_assembler_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       i_Ready;
  logic       o_Valid;
  logic [7:0] o_Cmd;
  logic [7:0] o_Addr;
  logic       o_Err;
  logic [2:0] o_Err_Code;
  logic [7:0] o_Err_Count;

  // Assembler side: consumes bytes and ready, produces frames and errors.
  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Ready,
    output o_Valid, o_Cmd, o_Addr, o_Err, o_Err_Code, o_Err_Count
  );

  // Environment side: the UART receiver and the downstream selector.
  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Ready,
    input  o_Valid, o_Cmd, o_Addr, o_Err, o_Err_Code, o_Err_Count
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_assembler
//  Description : Builds a command/address frame from the UART byte stream,
//                rejects bad commands, bad addresses, stalled frames and
//                overruns, and holds each frame until downstream accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_assembler #(
  parameter int unsigned CLKS_TIMEOUT = 50_000_000,
  parameter logic [7:0]  MAX_CMD      = 8'h06,
  parameter int unsigned NUM_ADDR     = 32
) (
  input  wire logic            i_Clock,
  input  wire logic            i_Reset_n,
  rx_frame_assembler_if.master bus
);

  localparam int unsigned            c_tmo_w    = (CLKS_TIMEOUT > 1) ? $clog2(CLKS_TIMEOUT) : 1;
  localparam logic [c_tmo_w-1:0]     c_tmo_last = c_tmo_w'(CLKS_TIMEOUT - 1);
  localparam logic [2:0]             c_err_cmd  = 3'd1;
  localparam logic [2:0]             c_err_addr = 3'd2;
  localparam logic [2:0]             c_err_tmo  = 3'd3;
  localparam logic [2:0]             c_err_ovr  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_PENDING   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_tmo_w-1:0]   r_tmo;
  logic [7:0]           r_cmd;
  logic [7:0]           r_addr;
  logic                 r_err;
  logic [2:0]           r_err_code;
  logic [7:0]           r_err_count;

  logic                 w_load_cmd;
  logic                 w_load_addr;
  logic                 w_clr_tmo;
  logic                 w_inc_tmo;
  logic                 w_err;
  logic [2:0]           w_err_code;
  logic                 w_cmd_ok;
  logic                 w_addr_ok;

  // Range checks are widened so NUM_ADDR can be compared at full width.
  assign w_cmd_ok  = (bus.i_Rx_Byte <= MAX_CMD);
  assign w_addr_ok = ({24'd0, bus.i_Rx_Byte} < NUM_ADDR);

  // State register; reset drops any partial or pending frame at once.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state decode plus datapath enables and error classification.
  always_comb begin
    w_state_nxt = r_state;
    w_load_cmd  = 1'b0;
    w_load_addr = 1'b0;
    w_clr_tmo   = 1'b0;
    w_inc_tmo   = 1'b0;
    w_err       = 1'b0;
    w_err_code  = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_Rx_DV) begin
          if (w_cmd_ok) begin
            w_load_cmd  = 1'b1;
            w_clr_tmo   = 1'b1;
            w_state_nxt = ST_WAIT_ADDR;
          end else begin
            w_err      = 1'b1;
            w_err_code = c_err_cmd;
          end
        end
      end
      ST_WAIT_ADDR: begin
        // A byte arriving in the timeout cycle wins over the timeout.
        if (bus.i_Rx_DV) begin
          if (w_addr_ok) begin
            w_load_addr = 1'b1;
            w_state_nxt = ST_PENDING;
          end else begin
            w_err       = 1'b1;
            w_err_code  = c_err_addr;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_tmo == c_tmo_last) begin
          w_err       = 1'b1;
          w_err_code  = c_err_tmo;
          w_state_nxt = ST_IDLE;
        end else begin
          w_inc_tmo = 1'b1;
        end
      end
      ST_PENDING: begin
        if (bus.i_Ready) w_state_nxt = ST_IDLE;
        // Bytes landing on a held frame are dropped even if it transfers now.
        if (bus.i_Rx_DV) begin
          w_err      = 1'b1;
          w_err_code = c_err_ovr;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame registers and stall counter; counter stops short of wrapping.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_cmd  <= 8'd0;
      r_addr <= 8'd0;
      r_tmo  <= '0;
    end else begin
      if (w_load_cmd)  r_cmd  <= bus.i_Rx_Byte;
      if (w_load_addr) r_addr <= bus.i_Rx_Byte;
      if (w_clr_tmo)      r_tmo <= '0;
      else if (w_inc_tmo) r_tmo <= r_tmo + 1'b1;
    end
  end

  // Error pulse, sticky cause and saturating error count.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_err       <= 1'b0;
      r_err_code  <= 3'd0;
      r_err_count <= 8'd0;
    end else begin
      r_err <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.o_Valid     = (r_state == ST_PENDING);
  assign bus.o_Cmd       = r_cmd;
  assign bus.o_Addr      = r_addr;
  assign bus.o_Err       = r_err;
  assign bus.o_Err_Code  = r_err_code;
  assign bus.o_Err_Count = r_err_count;

endmodule
`default_nettype wire

// File: doc/rx_frame_assembler.md
# rx_frame_assembler

Assembles the two-byte host request frame (command byte, then address byte) from the UART receiver's byte stream and delivers it to the request selector as one validated transaction. It sits between the UART receiver (byte + data-valid strobe) and the selector/sensor-interface path. It rejects unknown commands, out-of-range addresses and stalled frames. Each validated frame is held until the downstream stage accepts it.

## Interface

Parameters:
- CLKS_TIMEOUT, 50_000_000: maximum clocks allowed between command byte and address byte (1 s at 50 MHz).
- MAX_CMD, 8'h06: highest legal command code; legal range 0..MAX_CMD.
- NUM_ADDR, 32: number of sensor addresses; legal range 0..NUM_ADDR-1.

Ports:
- i_Clock  input  1  system clock; all state on rising edge.
- i_Reset_n  input  1  asynchronous active-low reset.
- i_Rx_DV  input  1  one-cycle strobe from UART receiver, byte valid.
- i_Rx_Byte  input  8  received byte; sampled only when i_Rx_DV=1.
- i_Ready  input  1  downstream can accept a frame this cycle.
- o_Valid  output  1  frame pending; level, held until accepted.
- o_Cmd  output  8  command byte of pending frame.
- o_Addr  output  8  address byte of pending frame.
- o_Err  output  1  one-cycle error pulse.
- o_Err_Code  output  3  cause of last error; holds until next error.
- o_Err_Count  output  8  errors since reset; saturates at 255.

## Operation

- Reset (asynchronous, i_Reset_n=0): state IDLE. All outputs 0, timeout counter 0.
- FSM states: IDLE, WAIT_ADDR, PENDING.
- IDLE, on i_Rx_DV:
  - i_Rx_Byte <= MAX_CMD: latch into o_Cmd, clear the timeout counter, go to WAIT_ADDR.
  - Otherwise: error code 1 (bad command), stay in IDLE.
- WAIT_ADDR:
  - Timeout counter increments every cycle.
  - On i_Rx_DV with i_Rx_Byte < NUM_ADDR: latch into o_Addr, go to PENDING.
  - On i_Rx_DV with i_Rx_Byte >= NUM_ADDR: error code 2 (bad address), go to IDLE.
  - No i_Rx_DV and counter == CLKS_TIMEOUT-1: error code 3 (timeout), go to IDLE.
  - i_Rx_DV in the timeout cycle: the byte is processed and the timeout is ignored.
- PENDING:
  - o_Valid=1; o_Cmd and o_Addr stay stable.
  - Transfer occurs on a cycle with o_Valid=1 and i_Ready=1. Next state IDLE, o_Valid=0.
  - i_Rx_DV while PENDING: byte discarded, error code 4 (overrun), state unchanged. If the same cycle also transfers, the transfer still completes and the byte is still discarded.
- Error action, any code:
  - o_Err=1 for exactly one cycle.
  - o_Err_Code updated.
  - o_Err_Count increments unless it is already 255.
- o_Cmd and o_Addr keep their last values outside PENDING. Consumers qualify them with o_Valid only.
- Timeout counter width is clog2(CLKS_TIMEOUT). The counter never wraps; it is cleared on entry to WAIT_ADDR.
- Reset asserted mid-frame discards any partial or pending frame immediately.

## Timing

- Command byte: the i_Rx_DV edge updates o_Cmd and enters WAIT_ADDR on that same edge.
- Address byte: o_Valid rises on the clock edge that samples the address i_Rx_DV, i.e. visible the cycle after the strobe. Latency is 1 cycle.
- o_Err, o_Err_Code and o_Err_Count update on the same edge that samples the offending strobe or the timeout condition.
- Timeout: the error fires exactly CLKS_TIMEOUT cycles after the command strobe edge when no address byte arrives.
- i_Ready=1 already when o_Valid rises: the frame transfers in that first cycle, and o_Valid is high for exactly 1 cycle.
- Back-to-back frames: a new command strobe accepted in IDLE on the cycle after a transfer is legal. Minimum frame spacing is therefore one idle cycle.
- No combinational paths from inputs to outputs.

## Test plan

- Reset, then frame 0x03/0x05 with i_Ready=1 -> o_Valid high 1 cycle, o_Cmd=0x03, o_Addr=0x05, o_Err never set.
- Command 0x07 -> o_Err pulse, o_Err_Code=1, o_Err_Count=1. Then 0x00/0x1F -> valid frame, o_Addr=0x1F.
- Command 0x01, then address 0x20 -> o_Err_Code=2, state IDLE. A following lone 0x02 is treated as a command.
- CLKS_TIMEOUT=100: command 0x01, no further byte -> o_Err exactly 100 cycles after the strobe, o_Err_Code=3. Repeat with the address strobe on cycle 99 -> frame valid, no error.
- i_Ready=0, frame 0x02/0x04, extra byte 0x06 while pending -> o_Err_Code=4, o_Cmd/o_Addr unchanged. Raise i_Ready -> transfer, o_Valid falls next cycle.
- Force 260 bad commands -> o_Err_Count=255. Assert i_Reset_n=0 while PENDING -> all outputs 0 immediately without a clock edge.
